// File: rtl/vga_reg_scan_ctrl.sv
// vga_reg_scan_ctrl
// Frame sequencer for the register-file display. Snapshots the eight CPU
// registers, walks the pixel generator over the scan window in raster order
// (x fastest) and forwards each colour to the VGA adapter through a one-entry
// valid/ready stage. A rescan is queued on refresh_req or whenever a live
// register differs from the displayed snapshot.
//
// Ports
//   CLOCK_50, resetn            clock, async active-low reset
//   R0..R7                      live register values
//   refresh_req                 single-cycle redraw request
//   pix_x, pix_y                coordinate presented to the pixel generator
//   snap_R0..snap_R7            snapshot values fed to the pixel generator
//   pix_color                   generator colour for (pix_x, pix_y)
//   vga_x, vga_y, vga_color     adapter write payload
//   vga_write, vga_ready        adapter write valid / accept
//   scan_busy                   frame in progress (LATCH..DONE)
//   frame_done                  one-cycle pulse after the last accepted write
//   frame_count                 completed frames, wraps
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for pending
// LATCH | load snapshot, clear pending, home the scan coordinates
// SCAN  | feed one window pixel into the output stage per advance
// DRAIN | wait for the adapter to accept the last write
// DONE  | frame_done pulse, frame_count increment

module vga_reg_scan_ctrl #(
   parameter int X_START = 40,
   parameter int Y_START = 40,
   parameter int WIN_W   = 128,
   parameter int WIN_H   = 304
) (
   input  logic        CLOCK_50,
   input  logic        resetn,
   input  logic [3:0]  R0,
   input  logic [3:0]  R1,
   input  logic [3:0]  R2,
   input  logic [3:0]  R3,
   input  logic [3:0]  R4,
   input  logic [3:0]  R5,
   input  logic [3:0]  R6,
   input  logic [3:0]  R7,
   input  logic        refresh_req,
   output logic [9:0]  pix_x,
   output logic [8:0]  pix_y,
   output logic [3:0]  snap_R0,
   output logic [3:0]  snap_R1,
   output logic [3:0]  snap_R2,
   output logic [3:0]  snap_R3,
   output logic [3:0]  snap_R4,
   output logic [3:0]  snap_R5,
   output logic [3:0]  snap_R6,
   output logic [3:0]  snap_R7,
   input  logic [23:0] pix_color,
   output logic [9:0]  vga_x,
   output logic [8:0]  vga_y,
   output logic [23:0] vga_color,
   output logic        vga_write,
   input  logic        vga_ready,
   output logic        scan_busy,
   output logic        frame_done,
   output logic [7:0]  frame_count
);

   localparam logic [9:0] X_FIRST = 10'(X_START);
   localparam logic [9:0] X_LAST  = 10'(X_START + WIN_W - 1);
   localparam logic [8:0] Y_FIRST = 9'(Y_START);
   localparam logic [8:0] Y_LAST  = 9'(Y_START + WIN_H - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LATCH,
      S_SCAN,
      S_DRAIN,
      S_DONE
   } state_t;

   state_t      state;
   state_t      state_next;
   logic        pending;
   logic        stage_adv;
   logic        last_pix;
   logic        regs_differ;
   logic [31:0] live_regs;
   logic [31:0] snap_regs;

   assign live_regs   = {R7, R6, R5, R4, R3, R2, R1, R0};
   assign regs_differ = (live_regs != snap_regs);
   // The output stage can take a new pixel when empty or being emptied.
   assign stage_adv   = !vga_write || vga_ready;
   assign last_pix    = (pix_x == X_LAST) && (pix_y == Y_LAST);

   assign {snap_R7, snap_R6, snap_R5, snap_R4,
           snap_R3, snap_R2, snap_R1, snap_R0} = snap_regs;

   assign scan_busy  = (state != S_IDLE);
   assign frame_done = (state == S_DONE);

   always_ff @(posedge CLOCK_50 or negedge resetn) begin
      if (!resetn) state <= S_IDLE;
      else         state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         S_IDLE:  if (pending) state_next = S_LATCH;
         S_LATCH: state_next = S_SCAN;
         S_SCAN:  if (stage_adv && last_pix) state_next = S_DRAIN;
         S_DRAIN: if (stage_adv) state_next = S_DONE;
         S_DONE:  state_next = S_IDLE;
         default: state_next = S_IDLE;
      endcase
   end

   // Requests and register changes arriving in LATCH are already covered by
   // the snapshot being taken, so they are absorbed there.
   always_ff @(posedge CLOCK_50 or negedge resetn) begin
      if (!resetn) begin
         pending <= 1'b1;
      end else if (state == S_LATCH) begin
         pending <= 1'b0;
      end else if (refresh_req || regs_differ) begin
         pending <= 1'b1;
      end
   end

   always_ff @(posedge CLOCK_50 or negedge resetn) begin
      if (!resetn) begin
         snap_regs <= '0;
      end else if (state == S_LATCH) begin
         snap_regs <= live_regs;
      end
   end

   // Stepping past the last pixel returns the coordinates home so they rest
   // at the window origin outside SCAN.
   always_ff @(posedge CLOCK_50 or negedge resetn) begin
      if (!resetn) begin
         pix_x <= X_FIRST;
         pix_y <= Y_FIRST;
      end else if (state == S_LATCH) begin
         pix_x <= X_FIRST;
         pix_y <= Y_FIRST;
      end else if (state == S_SCAN && stage_adv) begin
         if (last_pix) begin
            pix_x <= X_FIRST;
            pix_y <= Y_FIRST;
         end else if (pix_x == X_LAST) begin
            pix_x <= X_FIRST;
            pix_y <= pix_y + 9'd1;
         end else begin
            pix_x <= pix_x + 10'd1;
         end
      end
   end

   always_ff @(posedge CLOCK_50 or negedge resetn) begin
      if (!resetn) begin
         vga_x     <= '0;
         vga_y     <= '0;
         vga_color <= '0;
         vga_write <= 1'b0;
      end else if (state == S_SCAN && stage_adv) begin
         vga_x     <= pix_x;
         vga_y     <= pix_y;
         vga_color <= pix_color;
         vga_write <= 1'b1;
      end else if (vga_ready) begin
         vga_write <= 1'b0;
      end
   end

   always_ff @(posedge CLOCK_50 or negedge resetn) begin
      if (!resetn) begin
         frame_count <= '0;
      end else if (state == S_DONE) begin
         frame_count <= frame_count + 8'd1;
      end
   end

endmodule

// File: tb/tb_vga_reg_scan_ctrl.sv
// Bench for vga_reg_scan_ctrl, run on a reduced 16x4 window so that many
// frames fit in a short simulation. A negedge monitor compares every accepted
// write against the raster position computed from the write index, and checks
// stall stability, snapshot stability, frame length and frame_count.

module tb_vga_reg_scan_ctrl;

   localparam int X_START = 40;
   localparam int Y_START = 40;
   localparam int WIN_W   = 16;
   localparam int WIN_H   = 4;
   localparam int NPIX    = WIN_W * WIN_H;

   logic        clk = 1'b0;
   logic        resetn;
   logic        refresh_req;
   logic        vga_ready;
   logic [3:0]  r [8];
   logic [9:0]  pix_x, vga_x;
   logic [8:0]  pix_y, vga_y;
   logic [3:0]  snap_R0, snap_R1, snap_R2, snap_R3;
   logic [3:0]  snap_R4, snap_R5, snap_R6, snap_R7;
   logic [23:0] pix_color, vga_color;
   logic        vga_write, scan_busy, frame_done;
   logic [7:0]  frame_count;
   logic [31:0] snap_all;
   logic [31:0] regs_all;

   int tests = 0;
   int fails = 0;
   logic rnd_ready = 1'b0;

   // monitor / model state
   int          widx = 0;
   logic        in_frame = 1'b0;
   int          cyc_cnt = 0;
   int          frame_start = 0;
   int          stall_cnt = 0;
   int          frames_seen = 0;
   logic [7:0]  m_count = 8'd0;
   logic [31:0] m_snap = 32'd0;
   logic        prev_busy = 1'b0;
   logic        prev_stall = 1'b0;
   logic        prev_done = 1'b0;
   logic [9:0]  hold_x, hold_px, first_x, last_x, ex;
   logic [8:0]  hold_y, hold_py, first_y, last_y, ey;
   logic [23:0] hold_c;

   function automatic logic [23:0] color_fn(input logic [9:0] x, input logic [8:0] y,
                                            input logic [31:0] s);
      return {x, y, 5'h00} ^ s[23:0] ^ {s[31:24], 16'h0000};
   endfunction

   assign snap_all  = {snap_R7, snap_R6, snap_R5, snap_R4, snap_R3, snap_R2, snap_R1, snap_R0};
   assign regs_all  = {r[7], r[6], r[5], r[4], r[3], r[2], r[1], r[0]};
   assign pix_color = color_fn(pix_x, pix_y, snap_all);

   vga_reg_scan_ctrl #(
      .X_START(X_START), .Y_START(Y_START), .WIN_W(WIN_W), .WIN_H(WIN_H)
   ) dut (
      .CLOCK_50(clk), .resetn(resetn),
      .R0(r[0]), .R1(r[1]), .R2(r[2]), .R3(r[3]),
      .R4(r[4]), .R5(r[5]), .R6(r[6]), .R7(r[7]),
      .refresh_req(refresh_req),
      .pix_x(pix_x), .pix_y(pix_y),
      .snap_R0(snap_R0), .snap_R1(snap_R1), .snap_R2(snap_R2), .snap_R3(snap_R3),
      .snap_R4(snap_R4), .snap_R5(snap_R5), .snap_R6(snap_R6), .snap_R7(snap_R7),
      .pix_color(pix_color),
      .vga_x(vga_x), .vga_y(vga_y), .vga_color(vga_color),
      .vga_write(vga_write), .vga_ready(vga_ready),
      .scan_busy(scan_busy), .frame_done(frame_done), .frame_count(frame_count)
   );

   initial forever #5 clk = ~clk;

   initial begin
      #5_000_000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Monitor: sampled on the falling edge, between input updates.
   initial forever begin
      @(negedge clk);
      if (!resetn) begin
         chk("rst_vga", 64'({vga_write, vga_x, vga_y, vga_color}), 64'(0));
         chk("rst_status", 64'({scan_busy, frame_done, frame_count}), 64'(0));
         chk("rst_pix", 64'({pix_x, pix_y}), 64'({10'(X_START), 9'(Y_START)}));
         chk("rst_snap", 64'(snap_all), 64'(0));
         widx = 0; in_frame = 1'b0; stall_cnt = 0;
         m_count = 8'd0; m_snap = 32'd0;
         prev_busy = 1'b0; prev_stall = 1'b0; prev_done = 1'b0;
      end else begin
         cyc_cnt++;
         if (scan_busy && !prev_busy) begin
            in_frame = 1'b1; widx = 0; stall_cnt = 0;
            frame_start = cyc_cnt;
            m_snap = regs_all;
         end else begin
            chk("snap_stable", 64'(snap_all), 64'(m_snap));
         end
         if (!scan_busy)
            chk("pix_home", 64'({pix_x, pix_y}), 64'({10'(X_START), 9'(Y_START)}));
         if (prev_stall) begin
            chk("stall_hold", 64'({vga_write, vga_x, vga_y, vga_color}),
                64'({1'b1, hold_x, hold_y, hold_c}));
            chk("stall_pix", 64'({pix_x, pix_y}), 64'({hold_px, hold_py}));
         end
         if (vga_write && vga_ready) begin
            if (in_frame && widx < NPIX) begin
               ex = 10'(X_START + widx % WIN_W);
               ey = 9'(Y_START + widx / WIN_W);
               chk("write", 64'({vga_x, vga_y, vga_color}), 64'({ex, ey, color_fn(ex, ey, m_snap)}));
               if (widx == 0) begin first_x = vga_x; first_y = vga_y; end
               if (widx == NPIX - 1) begin last_x = vga_x; last_y = vga_y; end
            end else begin
               tests++; fails++;
               $display("FAIL extra_write actual=(%0d,%0d) idx=%0d required=no write", vga_x, vga_y, widx);
            end
            widx++;
         end
         if (vga_write && !vga_ready) stall_cnt++;
         if (frame_done) begin
            chk("frame_writes", 64'(widx), 64'(NPIX));
            chk("frame_len", 64'(cyc_cnt - frame_start), 64'(NPIX + 2 + stall_cnt));
            chk("frame_count_at_done", 64'(frame_count), 64'(m_count));
            m_count++;
            in_frame = 1'b0;
            frames_seen++;
            if (frames_seen == 1) begin
               chk("first_write_xy", 64'({first_x, first_y}), 64'({10'd40, 9'd40}));
               chk("last_write_xy", 64'({last_x, last_y}), 64'({10'd55, 9'd43}));
               chk("first_frame_len", 64'(cyc_cnt - frame_start), 64'(66));
            end
         end
         if (prev_done) chk("idle_after_done", 64'(scan_busy), 64'(0));
         prev_busy  = scan_busy;
         prev_stall = vga_write && !vga_ready;
         prev_done  = frame_done;
         hold_x = vga_x; hold_y = vga_y; hold_c = vga_color;
         hold_px = pix_x; hold_py = pix_y;
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
      if (rnd_ready) vga_ready = 1'($urandom_range(0, 1));
   endtask

   task automatic pulse_refresh();
      refresh_req = 1'b1;
      cyc();
      refresh_req = 1'b0;
   endtask

   task automatic wait_idle();
      int quiet = 0;
      int n = 0;
      while (quiet < 4 && n < 3000) begin
         cyc(); n++;
         if (!scan_busy) quiet++;
         else quiet = 0;
      end
      chk("wait_idle_timeout", 64'(quiet >= 4), 64'(1));
   endtask

   task automatic wait_widx(input int target);
      int n = 0;
      while (!(in_frame && widx >= target) && n < 5000) begin
         cyc(); n++;
      end
      chk("wait_widx_timeout", 64'(n < 5000), 64'(1));
   endtask

   initial begin
      int n;
      int dones;
      logic changed;
      resetn = 1'b0;
      refresh_req = 1'b0;
      vga_ready = 1'b1;
      for (int i = 0; i < 8; i++) r[i] = 4'd0;
      repeat (3) cyc();

      // first frame starts by itself after reset
      resetn = 1'b1;
      wait_idle();
      chk("t1_frame_count", 64'(frame_count), 64'(1));
      chk("t1_busy", 64'(scan_busy), 64'(0));

      // random back-pressure
      rnd_ready = 1'b1;
      pulse_refresh();
      wait_idle();
      rnd_ready = 1'b0;
      vga_ready = 1'b1;
      cyc();
      chk("t2_frame_count", 64'(frame_count), 64'(2));

      // register change mid-frame: one rescan with the new value
      pulse_refresh();
      wait_widx(20);
      r[3] = 4'd5;
      wait_idle();
      chk("t3_frame_count", 64'(frame_count), 64'(4));
      chk("t3_snap_r3", 64'(snap_R3), 64'(5));

      // two requests in SCAN, one in the next LATCH (absorbed)
      pulse_refresh();
      wait_widx(5);
      pulse_refresh();
      wait_widx(10);
      pulse_refresh();
      n = 0;
      while (!frame_done && n < 3000) begin cyc(); n++; end
      chk("t4_done_timeout", 64'(n < 3000), 64'(1));
      cyc();
      n = 0;
      while (!scan_busy && n < 100) begin cyc(); n++; end
      chk("t4_latch_timeout", 64'(n < 100), 64'(1));
      pulse_refresh();
      wait_idle();
      chk("t4_frame_count", 64'(frame_count), 64'(6));

      // reset in the middle of a frame
      pulse_refresh();
      wait_widx(30);
      resetn = 1'b0;
      #1;
      chk("t5_rst_now", 64'({vga_write, scan_busy, frame_count}), 64'(0));
      cyc(); cyc();
      resetn = 1'b1;
      wait_idle();
      chk("t5_frame_count", 64'(frame_count), 64'(1));

      // 256 back-to-back frames driven by register changes
      dones = 0;
      changed = 1'b0;
      n = 0;
      r[0] = r[0] + 4'd1;
      while (dones < 256 && n < 40000) begin
         cyc(); n++;
         if (frame_done) begin
            dones++;
            changed = 1'b0;
         end else if (in_frame && widx >= 3 && !changed && dones < 255) begin
            r[0] = r[0] + 4'd1;
            changed = 1'b1;
         end
      end
      chk("t6_done_pulses", 64'(dones), 64'(256));
      wait_idle();
      chk("t6_frame_count_wrap", 64'(frame_count), 64'(1));

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
